// File: rtl/mag_window_stats.sv
`default_nettype none
// ============================================================================
// Module  : mag_window_stats
// Brief   : Windowed average / max / min / over-threshold count of magnitude
//           samples, result held on a valid/ready output until consumed.
// Revision: 1.0 - initial release
// ============================================================================
module mag_window_stats #(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 3,
  parameter int SUM_W    = DATA_W + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   thresh,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_avg,
  output logic [DATA_W-1:0]   out_max,
  output logic [DATA_W-1:0]   out_min,
  output logic [WIN_LOG2:0]   out_over
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam logic [WIN_LOG2-1:0] c_cnt_last = '1;
  localparam logic [WIN_LOG2-1:0] c_cnt_one  = WIN_LOG2'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIN_LOG2-1:0]   r_count;
  logic [SUM_W-1:0]      r_sum;
  logic [DATA_W-1:0]     r_max;
  logic [DATA_W-1:0]     r_min;
  logic [WIN_LOG2:0]     r_over;

  logic                  w_accept;
  logic                  w_first;
  logic                  w_last;
  logic                  w_gt;
  logic [SUM_W-1:0]      w_sum_nxt;
  logic [DATA_W-1:0]     w_max_nxt;
  logic [DATA_W-1:0]     w_min_nxt;
  logic [WIN_LOG2:0]     w_over_nxt;

  assign w_accept   = in_valid & in_ready;
  assign w_first    = (r_count == '0);
  assign w_last     = (r_count == c_cnt_last);
  assign w_gt       = (in_data > thresh);
  assign w_sum_nxt  = r_sum + {{WIN_LOG2{1'b0}}, in_data};
  assign w_max_nxt  = (w_first || (in_data > r_max)) ? in_data : r_max;
  assign w_min_nxt  = (w_first || (in_data < r_min)) ? in_data : r_min;
  assign w_over_nxt = r_over + {{WIN_LOG2{1'b0}}, w_gt};

  // Handshake outputs depend only on registered state and ena, never on
  // in_valid or out_ready.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = ena;
        if (ena && in_valid && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (ena && out_ready) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else if (clear) begin
      r_state <= ST_ACCUM;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_sum    <= '0;
      r_max    <= '0;
      r_min    <= '1;
      r_over   <= '0;
      out_avg  <= '0;
      out_max  <= '0;
      out_min  <= '0;
      out_over <= '0;
    end else if (clear) begin
      r_count  <= '0;
      r_sum    <= '0;
      r_max    <= '0;
      r_min    <= '1;
      r_over   <= '0;
      out_avg  <= '0;
      out_max  <= '0;
      out_min  <= '0;
      out_over <= '0;
    end else if (ena) begin
      if (w_accept) begin
        r_count <= r_count + c_cnt_one;
        r_sum   <= w_sum_nxt;
        r_max   <= w_max_nxt;
        r_min   <= w_min_nxt;
        r_over  <= w_over_nxt;
        // Final sample: publish results that already include it.
        if (w_last) begin
          out_avg  <= w_sum_nxt[SUM_W-1:WIN_LOG2];
          out_max  <= w_max_nxt;
          out_min  <= w_min_nxt;
          out_over <= w_over_nxt;
        end
      end else if ((r_state == ST_DONE) && out_ready) begin
        r_count <= '0;
        r_sum   <= '0;
        r_max   <= '0;
        r_min   <= '1;
        r_over  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mag_window_stats.md
Name: mag_window_stats

Overview:
- Downstream consumer of the 8-bit vector-magnitude stage output, sqrt(x^2+y^2).
- Collects a fixed window of 2^WIN_LOG2 magnitude samples over a valid/ready handshake.
- At window end it publishes average, maximum, minimum, and the count of samples strictly above a programmable threshold.
- The result is held on a valid/ready output until it is consumed.

Parameters:
DATA_W, 8, magnitude sample width
WIN_LOG2, 3, log2 of window length (window = 8 samples by default); legal 1..6
SUM_W, DATA_W+WIN_LOG2, accumulator width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state
clear  input  1  synchronous window abort/restart
in_valid  input  1  magnitude sample valid
in_data  input  DATA_W  magnitude sample
in_ready  output  1  block can accept a sample
thresh  input  DATA_W  threshold, sampled with each accepted sample
out_valid  output  1  window result valid
out_ready  input  1  consumer accepts result
out_avg  output  DATA_W  floor(sum/2^WIN_LOG2)
out_max  output  DATA_W  window maximum
out_min  output  DATA_W  window minimum
out_over  output  WIN_LOG2+1  number of samples with in_data > thresh

Behaviour:
- One clock domain (clk). rst_n is asynchronous assert; state is cleared immediately on rst_n low.
- Reset values:
  - state = ACCUM, sample count = 0, sum = 0, running max = 0, running min = all-ones, over count = 0.
  - out_valid = 0; out_avg, out_max, out_min, out_over = 0.
- FSM, two states:
  - ACCUM: in_ready = ena. A sample is accepted when in_valid & in_ready.
  - DONE: in_ready = 0, out_valid = 1. Result registers are stable.
- Per accepted sample:
  - sum += in_data, computed at SUM_W, which cannot overflow.
  - On the first sample of a window (count == 0), running max and min both load in_data. Otherwise max = larger of (max, in_data) and min = smaller of (min, in_data), unsigned compare.
  - over count increments if in_data > thresh (strict). in_data == thresh does not count.
  - Sample count increments.
- Window completion: on acceptance of the 2^WIN_LOG2-th sample:
  - The next edge latches out_avg = (sum including this sample) >> WIN_LOG2 (truncate), plus out_max, out_min and out_over, all including this sample.
  - The same edge sets out_valid = 1 and moves to DONE.
  - Latency: out_valid rises exactly 1 cycle after the last sample handshake.
- DONE -> ACCUM when out_valid & out_ready & ena.
  - That edge clears out_valid, zeroes the accumulators and the count, and sets min to all-ones.
  - Result outputs keep their last values until the next window overwrites them.
  - in_ready reasserts the following cycle, so windows are separated by at least one cycle with no sample accepted.
- ena = 0:
  - No state changes; in_ready = 0.
  - out_valid holds its value and out_ready is ignored.
- clear = 1 (sync, priority over everything except rst_n):
  - Same effect as reset on all state and outputs.
  - A sample presented in the same cycle is dropped. A pending result in DONE is discarded.
  - clear acts regardless of ena.
- in_data and thresh are don't-care when no handshake occurs. in_valid may toggle freely; no holding requirement is placed on the upstream.
- No combinational path from in_valid to in_ready. No combinational path from out_ready to out_valid.

Test Plan:
- Default params, thresh = 45, stream 10,20,30,40,50,60,70,80 with in_valid held high and out_ready = 1.
  - Required: out_valid rises 1 cycle after the 8th handshake, with avg = 45, max = 80, min = 10, over = 4.
  - Required: out_valid drops the next cycle; in_ready returns 1 cycle later.
- Backpressure: window complete, out_ready = 0 for 6 cycles with in_valid = 1.
  - Required: out_valid stays 1, in_ready stays 0, outputs are constant, and no sample is counted.
  - After out_ready = 1, the next window counts only later samples.
- Saturation: eight samples of 255, thresh = 255.
  - Required: sum = 2040 with no overflow; avg = 255, max = min = 255, over = 0.
  - Rerun with thresh = 254: over = 8.
- Enable gating: ena = 0 for 3 cycles mid-window (after 4 samples) with in_valid = 1 and data = 200.
  - Required: in_ready = 0 and no count change.
  - Resume with samples 1,2,3,4 after first samples 5,6,7,8 -> avg = 4 (36>>3), min = 1, max = 8.
- clear after 5 accepted samples, then a fresh window of eight 16s.
  - Required: avg = 16, max = min = 16; none of the earlier samples contribute.
  - clear asserted while in DONE -> out_valid drops next edge.
- Async reset: assert rst_n low mid-window and between clock edges.
  - Required: out_valid and all outputs are 0 immediately.
  - After release, a full 8-sample window is required before out_valid.
